// File: rtl/cpu_defs_pkg.sv
// Shared CPU type definitions used by the ID-stage scoreboard.
package cpu_defs;

  typedef logic [4:0]  RegAddr_t;
  typedef logic        Bit_t;
  typedef logic [31:0] RegMask_t;

  // Default number of long-latency operations allowed in flight.
  localparam int SB_MAX_OUTSTANDING = 4;

endpackage : cpu_defs

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW detection against the pending mask.
// A same-cycle writeback can optionally hide the hazard.
module sb_hazard_check
  import cpu_defs::*;
#(
  parameter int BYPASS_WB = 1
) (
  input  RegMask_t pending_i,
  input  RegAddr_t raddr1_i,
  input  RegAddr_t raddr2_i,
  input  RegAddr_t waddr_i,
  input  Bit_t     we_i,
  input  Bit_t     wb_valid_i,
  input  RegAddr_t wb_waddr_i,
  output Bit_t     raw_o,
  output Bit_t     waw_o
);

  // A register is busy when it is pending and not being written back right now.
  function automatic Bit_t busy(input RegAddr_t r);
    Bit_t clr;
    clr  = (BYPASS_WB != 0) && wb_valid_i && (wb_waddr_i == r) && (r != 5'd0);
    busy = (r != 5'd0) && pending_i[r] && !clr;
  endfunction

  // Hazard flags for the instruction currently in ID.
  always_comb begin
    raw_o = busy(raddr1_i) | busy(raddr2_i);
    waw_o = we_i & busy(waddr_i);
  end

endmodule : sb_hazard_check

// File: rtl/id_scoreboard.sv
// Register scoreboard and issue controller between ID and EX.
// Tracks GPRs with outstanding long-latency writes, stalls on hazards,
// bounds the number of in-flight long ops and recovers on flush.
module id_scoreboard
  import cpu_defs::*;
#(
  parameter int MAX_OUTSTANDING = SB_MAX_OUTSTANDING,
  parameter int BYPASS_WB       = 1,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  input  logic [4:0]       id_waddr,
  input  logic             id_we,
  input  logic             id_long,
  input  logic             ex_ready,
  output logic             id_ready,
  output logic             issue_fire,
  input  logic             wb_valid,
  input  logic [4:0]       wb_waddr,
  input  logic             flush,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding,
  output logic             wb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  RegMask_t         pending_q, pending_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  Bit_t             wb_err_q, wb_err_d;
  Bit_t             raw, waw, full, set, inc, dec;

  sb_hazard_check #(
    .BYPASS_WB (BYPASS_WB)
  ) u_hazard (
    .pending_i  (pending_q),
    .raddr1_i   (id_raddr1),
    .raddr2_i   (id_raddr2),
    .waddr_i    (id_waddr),
    .we_i       (id_we),
    .wb_valid_i (wb_valid),
    .wb_waddr_i (wb_waddr),
    .raw_o      (raw),
    .waw_o      (waw)
  );

  // Issue handshake: a writeback this cycle frees a slot when bypass is on.
  always_comb begin
    full       = (outstanding_q == MAX_CNT) && !((BYPASS_WB != 0) && wb_valid);
    id_ready   = ex_ready & ~flush & ~raw & ~waw & ~(id_long & full);
    issue_fire = id_valid & id_ready;
  end

  // Next scoreboard state; set beats clear on the same register.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    wb_err_d      = 1'b0;
    set           = issue_fire & id_long & id_we & (id_waddr != 5'd0);
    inc           = issue_fire & id_long;
    // Counter saturates at zero on a spurious writeback.
    dec           = wb_valid & (outstanding_q != '0);
    if (flush) begin
      pending_d     = '0;
      outstanding_d = '0;
    end else begin
      if (wb_valid) begin
        pending_d[wb_waddr] = 1'b0;
      end
      if (set) begin
        pending_d[id_waddr] = 1'b1;
      end
      if (inc && !dec) begin
        outstanding_d = outstanding_q + 1'b1;
      end else if (dec && !inc) begin
        outstanding_d = outstanding_q - 1'b1;
      end
      wb_err_d = wb_valid &
                 ((outstanding_q == '0) || ((wb_waddr != 5'd0) && !pending_q[wb_waddr]));
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard state registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

endmodule : id_scoreboard

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard (MAX_OUTSTANDING = 2, BYPASS_WB = 1).
// Combinational outputs are checked before the edge; expected registered
// state is queued when a step is driven and popped after the edge.
module tb_id_scoreboard;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_we, id_long, ex_ready, wb_valid, flush;
  logic [4:0]       id_raddr1, id_raddr2, id_waddr, wb_waddr;
  logic             id_ready, issue_fire, wb_err;
  logic [31:0]      pending;
  logic [CNT_W-1:0] outstanding;

  typedef struct {
    int          step;
    logic [31:0] pend;
    logic [3:0]  outs;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  id_scoreboard #(
    .MAX_OUTSTANDING (2),
    .BYPASS_WB       (1),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_raddr1   (id_raddr1),
    .id_raddr2   (id_raddr2),
    .id_waddr    (id_waddr),
    .id_we       (id_we),
    .id_long     (id_long),
    .ex_ready    (ex_ready),
    .id_ready    (id_ready),
    .issue_fire  (issue_fire),
    .wb_valid    (wb_valid),
    .wb_waddr    (wb_waddr),
    .flush       (flush),
    .pending     (pending),
    .outstanding (outstanding),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clocked transaction: drive, check handshake, clock, check state.
  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] wa, input logic we, input logic lng,
                      input logic wbv, input logic [4:0] wba, input logic fl,
                      input logic exp_ready, input logic [31:0] exp_pend,
                      input logic [3:0] exp_out, input logic exp_err);
    exp_t e;
    exp_t got;
    step_no++;
    id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_waddr = wa;
    id_we = we; id_long = lng; ex_ready = 1'b1;
    wb_valid = wbv; wb_waddr = wba; flush = fl;
    #1;
    chk($sformatf("s%0d_id_ready", step_no), {31'd0, id_ready}, {31'd0, exp_ready});
    chk($sformatf("s%0d_issue_fire", step_no), {31'd0, issue_fire}, {31'd0, v & exp_ready});
    e.step = step_no; e.pend = exp_pend; e.outs = exp_out; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk($sformatf("s%0d_pending", got.step), pending, got.pend);
    chk($sformatf("s%0d_outstanding", got.step), {28'd0, outstanding}, {28'd0, got.outs});
    chk($sformatf("s%0d_wb_err", got.step), {31'd0, wb_err}, {31'd0, got.err});
    $display("step %0d: v=%0b ra=%0d,%0d wa=%0d long=%0b wb=%0b/%0d flush=%0b ready=%0b pend=%h out=%0d err=%0b",
             got.step, v, r1, r2, wa, lng, wbv, wba, fl, exp_ready, pending, outstanding, wb_err);
  endtask

  function automatic logic [31:0] m(input int a, input int b = 0);
    logic [31:0] r;
    r = '0;
    if (a != 0) r[a] = 1'b1;
    if (b != 0) r[b] = 1'b1;
    return r;
  endfunction

  initial begin
    // Reset held with an ADDU r3 <- r1, r2 presented.
    rst_n = 1'b0;
    id_valid = 1'b1; id_raddr1 = 5'd1; id_raddr2 = 5'd2; id_waddr = 5'd3;
    id_we = 1'b1; id_long = 1'b0; ex_ready = 1'b1;
    wb_valid = 1'b0; wb_waddr = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", pending, 32'd0);
    chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_issue_fire", {31'd0, issue_fire}, 32'd1);
    rst_n = 1'b1;

    //   v  r1 r2 wa we lg wbv wba fl  rdy pend      out err
    step(1, 1, 2, 3, 1, 0, 0, 0, 0,   1, m(0),      0, 0); // ADDU r3
    step(1, 0, 0, 5, 1, 1, 0, 0, 0,   1, m(5),      1, 0); // LW r5
    step(1, 5, 0, 6, 1, 0, 0, 0, 0,   0, m(5),      1, 0); // ADDU r6 <- r5 stalls
    step(1, 5, 0, 6, 1, 0, 0, 0, 0,   0, m(5),      1, 0); // still stalled
    step(1, 5, 0, 6, 1, 0, 1, 5, 0,   1, m(0),      0, 0); // wb r5 bypass
    // Capacity
    step(1, 0, 0, 1, 1, 1, 0, 0, 0,   1, m(1),      1, 0); // LW r1
    step(1, 0, 0, 2, 1, 1, 0, 0, 0,   1, m(1, 2),   2, 0); // LW r2
    step(1, 0, 0, 3, 1, 1, 0, 0, 0,   0, m(1, 2),   2, 0); // LW r3 full
    step(1, 0, 0, 4, 1, 0, 0, 0, 0,   1, m(1, 2),   2, 0); // ADDU r4 issues
    step(1, 0, 0, 3, 1, 1, 1, 1, 0,   1, m(2, 3),   2, 0); // LW r3 with wb r1
    // Same-register set/clear
    step(0, 0, 0, 0, 0, 0, 1, 2, 0,   1, m(3),      1, 0); // wb r2
    step(1, 0, 0, 7, 1, 1, 0, 0, 0,   1, m(3, 7),   2, 0); // LW r7
    step(1, 0, 0, 7, 1, 1, 1, 7, 0,   1, m(3, 7),   2, 0); // LW r7 + wb r7
    // Flush
    step(0, 0, 0, 0, 0, 0, 1, 3, 0,   1, m(7),      1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0,   1, m(0),      0, 0);
    step(1, 0, 0, 2, 1, 1, 0, 0, 0,   1, m(2),      1, 0); // LW r2
    step(1, 0, 0, 9, 1, 1, 0, 0, 0,   1, m(2, 9),   2, 0); // LW r9
    step(1, 0, 0, 4, 1, 1, 1, 2, 1,   0, m(0),      0, 0); // flush + LW r4 + wb r2
    // Illegal writeback and r0
    step(0, 0, 0, 0, 0, 0, 1, 12, 0,  1, m(0),      0, 1); // wb r12, nothing out
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, m(0),      0, 0); // pulse ends
    step(1, 0, 0, 0, 1, 1, 0, 0, 0,   1, m(0),      1, 0); // LW r0
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, m(0),      1, 0);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outstanding", {28'd0, outstanding}, 32'd0);
    chk("async_rst_pending", pending, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_id_scoreboard
